// File: rtl/controle_es_pkg.sv
// Shared constants for the CPU I/O controller: FSM state encoding,
// 7-segment patterns (active-low gfedcba) and the display range limit.
package controle_es_pkg;

    localparam logic [2:0] ST_EXEC         = 3'd0;
    localparam logic [2:0] ST_ESPERA_PRESS = 3'd1;
    localparam logic [2:0] ST_ESPERA_SOLTA = 3'd2;
    localparam logic [2:0] ST_LIBERA       = 3'd3;
    localparam logic [2:0] ST_HALT         = 3'd4;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [31:0] VALOR_MAX = 32'd9999;

    // 14 bits cover every value up to 9999
    localparam int BCD_BITS = 14;

    // Non-decimal nibbles never reach the display in practice; blank them.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/controle_es_if.sv
// CPU/user-side signal bundle of the I/O controller.
// slave = controller side, master = CPU/board side.
interface controle_es_if;
    logic        OpIn;
    logic        OpOut;
    logic        OpHalt;
    logic [31:0] dado_saida;
    logic [17:0] switches;
    logic        botao;
    logic [31:0] entrada_valor;
    logic        habilita_cpu;
    logic [27:0] display;
    logic        led_espera;
    logic        led_halt;

    modport slave (
        input  OpIn, OpOut, OpHalt, dado_saida, switches, botao,
        output entrada_valor, habilita_cpu, display, led_espera, led_halt
    );

    modport master (
        output OpIn, OpOut, OpHalt, dado_saida, switches, botao,
        input  entrada_valor, habilita_cpu, display, led_espera, led_halt
    );
endinterface

// File: rtl/controle_es_bin_bcd.sv
// Sequential double-dabble: 14 shifts after start, then one cycle to
// present the result with a single-cycle done pulse. A start while busy
// reloads and restarts from scratch.
module bin_bcd
    import controle_es_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [BCD_BITS-1:0] bin,
    output logic                done,
    output logic [15:0]         bcd
);

    genvar gi;

    logic [BCD_BITS-1:0] shift_reg;
    logic [15:0]         acc_reg;
    logic [3:0]          cnt_reg;
    logic                busy_reg;
    logic                fin_reg;
    logic [15:0]         adj;
    logic                unused_carry;

    // add-3 correction on every BCD digit before each shift
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                    (acc_reg[gi*4 +: 4] + 4'd3) :
                                    acc_reg[gi*4 +: 4];
        end
    endgenerate

    // the top digit overflows only for values the caller shows as dashes
    assign unused_carry = adj[15];

    // load / shift / present sequencing
    always_ff @(posedge clock) begin
        done <= 1'b0;
        if (!reset_n) begin
            shift_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            fin_reg   <= 1'b0;
            bcd       <= '0;
        end else if (start) begin
            shift_reg <= bin;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            fin_reg   <= 1'b0;
        end else if (busy_reg) begin
            acc_reg   <= {adj[14:0], shift_reg[BCD_BITS-1]};
            shift_reg <= {shift_reg[BCD_BITS-2:0], 1'b0};
            cnt_reg   <= cnt_reg + 4'd1;
            if (cnt_reg == 4'(BCD_BITS - 1)) begin
                busy_reg <= 1'b0;
                fin_reg  <= 1'b1;
            end
        end else if (fin_reg) begin
            bcd     <= acc_reg;
            done    <= 1'b1;
            fin_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/controle_es.sv
// CPU I/O controller: stalls the CPU on IN until the user confirms with the
// pushbutton, shows OUT values on four 7-segment digits, latches HALT.
// Optional macro CONTROLE_ES_DEBOUNCE_EN compiles in the pushbutton
// debouncer; without it the synchronized button level is used directly.
module controle_es
    import controle_es_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic          clock,
    input  logic          reset_n,
    controle_es_if.slave  cpu
);

    genvar gi;

    logic [2:0]  state_reg;
    logic [31:0] entrada_reg;
    logic        sync1_reg;
    logic        sync2_reg;
    logic        deb_reg;
    logic        deb_prev_reg;
    logic        press_evt;
    logic        release_evt;
    logic        habilita;
    logic        out_start;
    logic        over_reg;
    logic        bcd_done;
    logic [15:0] bcd_value;
    logic [27:0] digits_seg;
    logic [27:0] display_reg;

    // two-flop synchronizer; idle level is released (high)
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= cpu.botao;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef CONTROLE_ES_DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    logic [CNT_W-1:0] deb_cnt_reg;

    // accept a level change only after it has been stable long enough
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            deb_reg     <= 1'b1;
            deb_cnt_reg <= '0;
        end else if (sync2_reg == deb_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
            deb_reg     <= sync2_reg;
            deb_cnt_reg <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (DEB_CYCLES != 0);

    // no filtering: debounced level follows the synchronizer
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            deb_reg <= 1'b1;
        end else begin
            deb_reg <= sync2_reg;
        end
    end
`endif

    // previous debounced level for edge detection
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            deb_prev_reg <= 1'b1;
        end else begin
            deb_prev_reg <= deb_reg;
        end
    end

    // button is active-low: press = 1->0, release = 0->1
    assign press_evt   = deb_prev_reg & ~deb_reg;
    assign release_evt = ~deb_prev_reg & deb_reg;

    // IN/HALT sequencing; only edges seen inside a wait state count
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= ST_EXEC;
            entrada_reg <= '0;
        end else begin
            case (state_reg)
                ST_EXEC: begin
                    if (cpu.OpHalt) begin
                        state_reg <= ST_HALT;
                    end else if (cpu.OpIn) begin
                        state_reg <= ST_ESPERA_PRESS;
                    end
                end
                ST_ESPERA_PRESS: begin
                    if (press_evt) begin
                        entrada_reg <= {14'b0, cpu.switches};
                        state_reg   <= ST_ESPERA_SOLTA;
                    end
                end
                ST_ESPERA_SOLTA: begin
                    if (release_evt) begin
                        state_reg <= ST_LIBERA;
                    end
                end
                ST_LIBERA: state_reg <= ST_EXEC;
                ST_HALT:   state_reg <= ST_HALT;
                default:   state_reg <= ST_EXEC;
            endcase
        end
    end

    // CPU clock enable: stall on IN/HALT, one release cycle after confirm
    always_comb begin
        habilita = 1'b0;
        case (state_reg)
            ST_LIBERA: habilita = 1'b1;
            ST_EXEC:   habilita = ~(cpu.OpIn | cpu.OpHalt);
            default:   habilita = 1'b0;
        endcase
    end

    assign out_start = (state_reg == ST_EXEC) & habilita & cpu.OpOut;

    bin_bcd u_bin_bcd (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (out_start),
        .bin     (cpu.dado_saida[BCD_BITS-1:0]),
        .done    (bcd_done),
        .bcd     (bcd_value)
    );

    // digit encoding, units in the low bits
    generate
        for (gi = 0; gi < 4; gi++) begin : g_seg
            assign digits_seg[gi*7 +: 7] = seg7(bcd_value[gi*4 +: 4]);
        end
    endgenerate

    // remember over-range at sampling; update the display when BCD is ready
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            over_reg    <= 1'b0;
            display_reg <= {4{SEG_TABLE[0]}};
        end else begin
            if (out_start) begin
                over_reg <= (cpu.dado_saida > VALOR_MAX);
            end
            if (bcd_done) begin
                display_reg <= over_reg ? {4{SEG_DASH}} : digits_seg;
            end
        end
    end

    assign cpu.entrada_valor = entrada_reg;
    assign cpu.habilita_cpu  = habilita;
    assign cpu.display       = display_reg;
    assign cpu.led_espera    = (state_reg == ST_ESPERA_PRESS) |
                               (state_reg == ST_ESPERA_SOLTA);
    assign cpu.led_halt      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_controle_es.sv
// Bench for controle_es with DEB_CYCLES=4: OUT conversion vectors checked
// through an expected-display queue, plus IN / HALT / reset sequences.
module tb_controle_es;

    localparam logic [27:0] DISP_ZERO = {4{7'b1000000}};
    localparam logic [27:0] DISP_DASH = {4{7'b0111111}};
    localparam logic [27:0] DISP_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    localparam logic [27:0] DISP_0007 = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000};

    typedef struct {
        logic [31:0] dado;
        logic [27:0] disp;
    } out_vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    out_vec_t    vecs [8];
    logic [27:0] exp_q [$];

    always #5 clock = ~clock;

    controle_es_if bus();

    controle_es #(.DEB_CYCLES(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .cpu     (bus)
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] exp_disp(input logic [31:0] v);
        int n;
        if (v > 32'd9999) return DISP_DASH;
        n = int'(v);
        return {seg(n / 1000), seg((n / 100) % 10), seg((n / 10) % 10), seg(n % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] shown;
        logic [27:0] e;
        bit          ok;
        bit          hab_ok;
        int          pulses;

        vecs[0] = '{32'd1234,       DISP_1234};
        vecs[1] = '{32'd10000,      DISP_DASH};
        vecs[2] = '{32'd0,          exp_disp(32'd0)};
        vecs[3] = '{32'd9999,       exp_disp(32'd9999)};
        vecs[4] = '{32'd7,          DISP_0007};
        vecs[5] = '{32'd16383,      DISP_DASH};
        vecs[6] = '{32'hFFFF_FFFF,  DISP_DASH};
        vecs[7] = '{32'd5678,       exp_disp(32'd5678)};

        bus.OpIn = 0; bus.OpOut = 0; bus.OpHalt = 0;
        bus.dado_saida = 0; bus.switches = 0; bus.botao = 1;

        // ---- reset state
        reset_n = 0;
        steps(2);
        reset_n = 1;
        chk("rst_display", bus.display, DISP_ZERO);
        chk("rst_entrada", bus.entrada_valor, 0);
        chk("rst_led_espera", bus.led_espera, 0);
        chk("rst_led_halt", bus.led_halt, 0);
        chk("rst_habilita", bus.habilita_cpu, 1);
        $display("reset: display=%h habilita=%b", bus.display, bus.habilita_cpu);

        // ---- OUT vectors: update exactly at the 16th edge, old value held before
        shown = DISP_ZERO;
        foreach (vecs[i]) begin
            bus.dado_saida = vecs[i].dado;
            bus.OpOut = 1;
            #1;
            hab_ok = (bus.habilita_cpu === 1'b1);
            exp_q.push_back(vecs[i].disp);
            step();
            bus.OpOut = 0;
            ok = 1;
            for (int c = 1; c < 16; c++) begin
                step();
                if (bus.display !== shown) ok = 0;
                if (bus.habilita_cpu !== 1'b1) hab_ok = 0;
            end
            step();
            e = exp_q.pop_front();
            chk("out_hold", ok, 1);
            chk("out_display", bus.display, e);
            chk("out_habilita", hab_ok, 1);
            $display("out vec %0d: dado=%0d display=%h", i, vecs[i].dado, bus.display);
            shown = e;
        end

        // ---- restart: 10000 then 7 at conversion cycle 5, latest wins
        bus.dado_saida = 32'd10000;
        bus.OpOut = 1;
        exp_q.push_back(DISP_DASH);
        step();
        bus.OpOut = 0;
        steps(4);
        bus.dado_saida = 32'd7;
        bus.OpOut = 1;
        exp_q.delete();
        exp_q.push_back(DISP_0007);
        step();
        bus.OpOut = 0;
        ok = 1;
        for (int c = 1; c < 16; c++) begin
            step();
            if (bus.display === DISP_DASH || bus.display !== shown) ok = 0;
        end
        step();
        chk("restart_nodash", ok, 1);
        chk("restart_display", bus.display, exp_q.pop_front());
        chk("queue_empty", exp_q.size(), 0);
        $display("restart: display=%h", bus.display);

        // ---- IN with press/release
        pulse_reset();
        bus.switches = 18'h00ABC;
        bus.OpIn = 1;
        #1;
        chk("in_stall", bus.habilita_cpu, 0);
        step();
        chk("in_led_espera", bus.led_espera, 1);
        bus.botao = 0;
        steps(10);
        chk("in_capture", bus.entrada_valor, 32'h0000_0ABC);
        chk("in_led_espera_held", bus.led_espera, 1);
        chk("in_stall_held", bus.habilita_cpu, 0);
        bus.switches = 18'h3FFFF;
        bus.botao = 1;
        pulses = 0;
        ok = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.habilita_cpu === 1'b1) begin
                pulses++;
                if (bus.led_espera !== 1'b0) ok = 0;
            end
        end
        chk("in_one_pulse", pulses, 1);
        chk("in_pulse_led", ok, 1);
        chk("in_value_kept", bus.entrada_valor, 32'h0000_0ABC);
        $display("in: entrada=%h pulses=%0d", bus.entrada_valor, pulses);
        bus.OpIn = 0;
        pulse_reset();

`ifdef CONTROLE_ES_DEBOUNCE_EN
        // ---- bouncing button in ESPERA_PRESS is ignored
        bus.switches = 18'h12345;
        bus.OpIn = 1;
        step();
        ok = 1;
        for (int c = 0; c < 20; c++) begin
            bus.botao = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            if (bus.habilita_cpu !== 1'b0 || bus.led_espera !== 1'b1) ok = 0;
        end
        bus.botao = 1;
        steps(3);
        chk("bounce_state", ok, 1);
        chk("bounce_entrada", bus.entrada_valor, 0);
        chk("bounce_led", bus.led_espera, 1);
        $display("bounce: entrada=%h led_espera=%b", bus.entrada_valor, bus.led_espera);
        bus.OpIn = 0;
        pulse_reset();
`endif

        // ---- press already held on entry does not count
        bus.botao = 0;
        steps(10);
        bus.switches = 18'h00155;
        bus.OpIn = 1;
        step();
        steps(10);
        chk("held_no_capture", bus.entrada_valor, 0);
        chk("held_waiting", bus.led_espera, 1);
        bus.botao = 1;
        steps(10);
        bus.botao = 0;
        steps(10);
        chk("held_new_press", bus.entrada_valor, 32'h0000_0155);
        $display("held press: entrada=%h", bus.entrada_valor);
        bus.botao = 1;
        bus.OpIn = 0;
        pulse_reset();

        // ---- HALT is sticky until reset
        bus.OpHalt = 1;
        #1;
        chk("halt_stall", bus.habilita_cpu, 0);
        step();
        ok = 1;
        for (int c = 0; c < 100; c++) begin
            if (c == 10) bus.OpHalt = 0;
            step();
            if (bus.habilita_cpu !== 1'b0 || bus.led_halt !== 1'b1) ok = 0;
        end
        chk("halt_held", ok, 1);
        pulse_reset();
        chk("halt_reset_led", bus.led_halt, 0);
        chk("halt_reset_hab", bus.habilita_cpu, 1);
        $display("halt: led_halt=%b habilita=%b", bus.led_halt, bus.habilita_cpu);

        // ---- reset during ESPERA_SOLTA discards the wait
        bus.switches = 18'h002A5;
        bus.OpIn = 1;
        step();
        bus.botao = 0;
        steps(10);
        chk("solta_capture", bus.entrada_valor, 32'h0000_02A5);
        reset_n = 0;
        bus.botao = 1;
        step();
        reset_n = 1;
        chk("solta_rst_entrada", bus.entrada_valor, 0);
        chk("solta_rst_led", bus.led_espera, 0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.habilita_cpu === 1'b1) pulses++;
        end
        chk("solta_no_libera", pulses, 0);
        $display("reset in solta: entrada=%h pulses=%0d", bus.entrada_valor, pulses);
        bus.OpIn = 0;
        pulse_reset();

        // ---- reset mid-conversion aborts it
        bus.dado_saida = 32'd4321;
        bus.OpOut = 1;
        step();
        bus.OpOut = 0;
        steps(5);
        pulse_reset();
        ok = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.display !== DISP_ZERO) ok = 0;
        end
        chk("conv_abort", ok, 1);
        $display("reset mid-conversion: display=%h", bus.display);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_es.md
CONTROLE_ES -- requirements
Module: controle_es

Interface
REQ-001 Parameter DEB_CYCLES, default 50000, number of stable clock cycles required to accept a button level change.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset: one clock, synchronous, active-low.
REQ-004 OpIn  input  1  CPU is executing IN; needs a user-supplied value.
REQ-005 OpOut  input  1  CPU is executing OUT; dado_saida must be shown.
REQ-006 OpHalt  input  1  CPU is executing HALT.
REQ-007 dado_saida  input  32  register value to display, unsigned.
REQ-008 switches  input  18  raw user data switches.
REQ-009 botao  input  1  raw asynchronous confirm pushbutton, active-low (pressed = 0).
REQ-010 entrada_valor  output  32  {14'b0, switches} captured on confirm, fed to the CPU's input path.
REQ-011 habilita_cpu  output  1  CPU clock enable; 0 stalls PC and register writes.
REQ-012 display  output  28  four 7-segment digits, active-low gfedcba; [6:0] = units … [27:21] = thousands.
REQ-013 led_espera  output  1  high while waiting for the user.
REQ-014 led_halt  output  1  high once halted.

Function
REQ-015 botao SHALL pass through a 2-flop synchronizer before any use.
REQ-016 Debounce: counter increments while the synchronized level differs from the debounced level, clears when equal; on reaching DEB_CYCLES-1 the debounced level SHALL flip and the counter clear.
REQ-017 FSM states: EXEC, ESPERA_PRESS, ESPERA_SOLTA, LIBERA, HALT.
REQ-018 EXEC: OpHalt -> HALT; else OpIn -> ESPERA_PRESS; priority OpHalt > OpIn > OpOut.
REQ-019 habilita_cpu SHALL be combinational: 1 in LIBERA; 1 in EXEC unless OpIn or OpHalt is high; 0 in all other states.
REQ-020 ESPERA_PRESS: on the debounced press edge, SHALL capture switches into entrada_valor and go to ESPERA_SOLTA.
REQ-021 ESPERA_SOLTA: on the debounced release edge, SHALL go to LIBERA; LIBERA lasts exactly one cycle, then EXEC.
REQ-022 A press already held on entry to ESPERA_PRESS SHALL NOT count; a new press edge is required.
REQ-023 led_espera = 1 in ESPERA_PRESS and ESPERA_SOLTA; led_halt = 1 in HALT; HALT is left only by reset.
REQ-024 OpOut SHALL be sampled only in EXEC with habilita_cpu = 1; sampling starts a BCD conversion of dado_saida.
REQ-025 display SHALL update at the 16th rising edge after the sampling edge; the old value is held until then.
REQ-026 A new OpOut during conversion SHALL restart the conversion with the new value (latest wins).
REQ-027 dado_saida > 9999 SHALL show four dashes (7'b0111111 per digit); leading zeros are shown.
REQ-028 OUT SHALL NOT stall the CPU.

Reset
REQ-029 reset_n low at a rising edge SHALL force: state EXEC, entrada_valor 0, display "0000" (7'b1000000 per digit), led_espera 0, led_halt 0, debounced level released, counter 0, conversion aborted.
REQ-030 Reset in any state, including mid-wait or mid-conversion, SHALL discard pending work.

Configuration
REQ-031 Macro CONTROLE_ES_DEBOUNCE_EN defined: REQ-016 debounce is compiled in.
REQ-032 CONTROLE_ES_DEBOUNCE_EN undefined: the synchronized level is used directly as the debounced level, the counter is absent, and DEB_CYCLES is ignored.

Structure
REQ-033 Package controle_es_pkg SHALL hold the FSM state encoding, the 7-segment digit table 0-9, the dash and the BLANK constants, and the 9999 limit.
REQ-034 Sub-module bin_bcd SHALL perform a sequential 14-shift double-dabble with start/done handshake; the dash/over-range decision stays in controle_es.

Verification (DEB_CYCLES=4, debounce enabled)
REQ-035 OpIn=1, switches=18'h00ABC, botao low for 10 cycles then high: habilita_cpu=0 in the OpIn cycle, entrada_valor=32'h00000ABC after the press, led_espera=1, then exactly one habilita_cpu=1 pulse after release.
REQ-036 In ESPERA_PRESS, botao toggled every 2 cycles for 20 cycles: state, entrada_valor and habilita_cpu stay unchanged.
REQ-037 OpOut with dado_saida=1234: display = {7'b0110011? no: digits 1,2,3,4 = 1111001,0100100,0110000,0011001} at the 16th edge; habilita_cpu stays 1 throughout.
REQ-038 OpOut with 10000: four dashes; a second OpOut with 7 at conversion cycle 5: final display "0007" and no dashes.
REQ-039 OpHalt=1: habilita_cpu=0 and led_halt=1 for 100 cycles; reset_n low for one edge: EXEC, habilita_cpu=1.
REQ-040 Reset during ESPERA_SOLTA: EXEC, entrada_valor=0, led_espera=0, and no LIBERA pulse.
